// File: rtl/clock_reset_sequencer_if.sv
// Signal bundle between the clock/reset sequencer and its PLLs and domain consumers.
interface clock_reset_sequencer_if;
  logic       restart;
  logic       pll_main_lock;
  logic       pll_ram_lock;
  logic       pll_main_rst;
  logic       pll_ram_rst;
  logic       rst_main_domain;
  logic       rst_ram_domain;
  logic       clocks_ready;
  logic [7:0] retry_count;
  logic [7:0] lock_loss_count;

  // Sequencer side: sees requests and raw LOCKED pins, drives resets and status.
  modport master (
    input  restart, pll_main_lock, pll_ram_lock,
    output pll_main_rst, pll_ram_rst, rst_main_domain, rst_ram_domain,
           clocks_ready, retry_count, lock_loss_count
  );

  // Environment side: PLLs, software and reset consumers.
  modport slave (
    output restart, pll_main_lock, pll_ram_lock,
    input  pll_main_rst, pll_ram_rst, rst_main_domain, rst_ram_domain,
           clocks_ready, retry_count, lock_loss_count
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Power-up / recovery sequencer for the main MMCM and the RAM PLL.
// Runs on the free-running board clock; releases main-PLL domains first,
// then RAM-PLL domains, and re-runs on lock loss or software restart.
module clock_reset_sequencer #(
  parameter int unsigned RESET_PULSE_CYCLES  = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned RELEASE_GAP_CYCLES  = 8
) (
  input logic                     clk,
  input logic                     rst,
  clock_reset_sequencer_if.master bus
);

  localparam int unsigned PULSE_W   = $clog2(RESET_PULSE_CYCLES + 1);
  localparam int unsigned STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W     = $clog2(RELEASE_GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_PLL_RESET    = 2'd0,
    S_WAIT_LOCK    = 2'd1,
    S_RELEASE_MAIN = 2'd2,
    S_RUN          = 2'd3
  } state_t;

  state_t               state;
  logic [PULSE_W-1:0]   pulse_cnt;
  logic [STABLE_W-1:0]  stable_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic [GAP_W-1:0]     gap_cnt;

  logic       pll_rst;
  logic       rst_main;
  logic       rst_ram;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  logic main_sync1, main_sync2;
  logic ram_sync1, ram_sync2;

  logic                 locked;
  logic [STABLE_W-1:0]  stable_nxt;
  logic [TIMEOUT_W-1:0] timeout_nxt;
  logic [GAP_W-1:0]     gap_nxt;
  logic                 pulse_done;
  logic                 stable_done;
  logic                 timeout_done;
  logic                 gap_done;

  // Two-flop synchronizers for the asynchronous LOCKED pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_sync1 <= 1'b0;
      main_sync2 <= 1'b0;
      ram_sync1  <= 1'b0;
      ram_sync2  <= 1'b0;
    end else begin
      main_sync1 <= bus.pll_main_lock;
      main_sync2 <= main_sync1;
      ram_sync1  <= bus.pll_ram_lock;
      ram_sync2  <= ram_sync1;
    end
  end

  assign locked       = main_sync2 & ram_sync2;
  assign stable_nxt   = locked ? stable_cnt + STABLE_W'(1) : '0;
  assign timeout_nxt  = timeout_cnt + TIMEOUT_W'(1);
  assign gap_nxt      = gap_cnt + GAP_W'(1);
  assign pulse_done   = (pulse_cnt == PULSE_W'(RESET_PULSE_CYCLES - 1));
  assign stable_done  = (stable_nxt == STABLE_W'(LOCK_STABLE_CYCLES));
  assign timeout_done = (timeout_nxt == TIMEOUT_W'(LOCK_TIMEOUT_CYCLES));
  assign gap_done     = (gap_nxt == GAP_W'(RELEASE_GAP_CYCLES));

  // Sequencer FSM with registered outputs; every path back to PLL_RESET re-asserts all resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_PLL_RESET;
      pulse_cnt   <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      gap_cnt     <= '0;
      pll_rst     <= 1'b1;
      rst_main    <= 1'b1;
      rst_ram     <= 1'b1;
      ready       <= 1'b0;
      retry_cnt   <= '0;
      loss_cnt    <= '0;
    end else begin
      case (state)
        S_PLL_RESET: begin
          if (pulse_done) begin
            state       <= S_WAIT_LOCK;
            pll_rst     <= 1'b0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PULSE_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (bus.restart) begin
            state     <= S_PLL_RESET;
            pulse_cnt <= '0;
            pll_rst   <= 1'b1;
          end else if (stable_done) begin
            state    <= S_RELEASE_MAIN;
            rst_main <= 1'b0;
            gap_cnt  <= '0;
          end else if (timeout_done) begin
            state     <= S_PLL_RESET;
            pulse_cnt <= '0;
            pll_rst   <= 1'b1;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            stable_cnt  <= stable_nxt;
            timeout_cnt <= timeout_nxt;
          end
        end

        S_RELEASE_MAIN, S_RUN: begin
          if (bus.restart || !locked) begin
            state     <= S_PLL_RESET;
            pulse_cnt <= '0;
            pll_rst   <= 1'b1;
            rst_main  <= 1'b1;
            rst_ram   <= 1'b1;
            ready     <= 1'b0;
            // Restart wins over a coincident lock loss, so that cycle is not counted.
            if (!bus.restart && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
          end else if (state == S_RELEASE_MAIN) begin
            if (gap_done) begin
              state   <= S_RUN;
              rst_ram <= 1'b0;
              ready   <= 1'b1;
            end else begin
              gap_cnt <= gap_nxt;
            end
          end
        end

        default: begin
          state     <= S_PLL_RESET;
          pulse_cnt <= '0;
          pll_rst   <= 1'b1;
          rst_main  <= 1'b1;
          rst_ram   <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_main_rst    = pll_rst;
  assign bus.pll_ram_rst     = pll_rst;
  assign bus.rst_main_domain = rst_main;
  assign bus.rst_ram_domain  = rst_ram;
  assign bus.clocks_ready    = ready;
  assign bus.retry_count     = retry_cnt;
  assign bus.lock_loss_count = loss_cnt;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench for clock_reset_sequencer: stimulus queues expected output
// snapshots tagged with a cycle number; a negedge monitor pops and compares.
module tb_clock_reset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   p0  = 0;
  int   checks = 0;
  int   errors = 0;

  clock_reset_sequencer_if bus();

  clock_reset_sequencer #(
    .RESET_PULSE_CYCLES (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(64),
    .RELEASE_GAP_CYCLES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used to tag expectations.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          when;
    int          id;
    logic [20:0] exp;
  } exp_t;

  exp_t sb[$];

  // {pll_main_rst, pll_ram_rst, rst_main_domain, rst_ram_domain, clocks_ready, retry, loss}
  function automatic logic [20:0] ev(input logic pr, input logic rm, input logic rr,
                                     input logic rdy, input logic [7:0] rc,
                                     input logic [7:0] lc);
    return {pr, pr, rm, rr, rdy, rc, lc};
  endfunction

  task automatic push(input int t, input int id, input logic [20:0] v);
    exp_t e;
    e.when = p0 + t;
    e.id   = id;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int t);
    while (cyc < p0 + t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.restart = 1'b0;
    bus.pll_main_lock = 1'b0;
    bus.pll_ram_lock = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    p0 = cyc;
  endtask

  // Monitor: compare DUT outputs against every expectation due this cycle.
  logic [20:0] act;
  exp_t        cur;
  always @(negedge clk) begin
    act = {bus.pll_main_rst, bus.pll_ram_rst, bus.rst_main_domain, bus.rst_ram_domain,
           bus.clocks_ready, bus.retry_count, bus.lock_loss_count};
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.when != cyc) begin
        errors++;
        $display("FAIL missed id=%0d actual cycle %0d required cycle %0d", cur.id, cyc, cur.when);
      end else if (act !== cur.exp) begin
        errors++;
        $display("FAIL check id=%0d cycle=%0d actual=%06h required=%06h", cur.id, cyc, act, cur.exp);
      end
    end
  end

  initial begin
    bus.restart = 1'b0;
    bus.pll_main_lock = 1'b0;
    bus.pll_ram_lock = 1'b0;

    // Nominal bring-up: locks rise at t=10, synced at t=12, release at t=20, run at t=22.
    do_reset();
    push(0,  1, ev(1, 1, 1, 0, 8'd0, 8'd0));
    push(3,  2, ev(1, 1, 1, 0, 8'd0, 8'd0));
    push(4,  3, ev(0, 1, 1, 0, 8'd0, 8'd0));
    push(19, 4, ev(0, 1, 1, 0, 8'd0, 8'd0));
    push(20, 5, ev(0, 0, 1, 0, 8'd0, 8'd0));
    push(21, 6, ev(0, 0, 1, 0, 8'd0, 8'd0));
    push(22, 7, ev(0, 0, 0, 1, 8'd0, 8'd0));
    push(30, 8, ev(0, 0, 0, 1, 8'd0, 8'd0));
    at(10);
    bus.pll_main_lock = 1'b1;
    bus.pll_ram_lock = 1'b1;
    at(31);

    // Glitch in wait, lock loss in RUN, restart+loss, restart in PLL_RESET, rst in RELEASE_MAIN.
    do_reset();
    push(25, 10, ev(0, 1, 1, 0, 8'd0, 8'd0));
    push(26, 11, ev(0, 0, 1, 0, 8'd0, 8'd0));
    push(28, 12, ev(0, 0, 0, 1, 8'd0, 8'd0));
    push(32, 13, ev(0, 0, 0, 1, 8'd0, 8'd0));
    push(33, 14, ev(1, 1, 1, 0, 8'd0, 8'd1));
    push(36, 15, ev(1, 1, 1, 0, 8'd0, 8'd1));
    push(37, 16, ev(0, 1, 1, 0, 8'd0, 8'd1));
    push(44, 17, ev(0, 1, 1, 0, 8'd0, 8'd1));
    push(45, 18, ev(0, 0, 1, 0, 8'd0, 8'd1));
    push(47, 19, ev(0, 0, 0, 1, 8'd0, 8'd1));
    push(52, 20, ev(0, 0, 0, 1, 8'd0, 8'd1));
    push(53, 21, ev(1, 1, 1, 0, 8'd0, 8'd1));
    push(56, 22, ev(1, 1, 1, 0, 8'd0, 8'd1));
    push(57, 23, ev(0, 1, 1, 0, 8'd0, 8'd1));
    push(65, 24, ev(0, 0, 1, 0, 8'd0, 8'd1));
    push(66, 25, ev(1, 1, 1, 0, 8'd0, 8'd0));
    at(10);
    bus.pll_main_lock = 1'b1;
    bus.pll_ram_lock = 1'b1;
    at(15);
    bus.pll_ram_lock = 1'b0;
    at(16);
    bus.pll_ram_lock = 1'b1;
    at(30);
    bus.pll_main_lock = 1'b0;
    at(33);
    bus.pll_main_lock = 1'b1;
    at(50);
    bus.pll_main_lock = 1'b0;
    at(52);
    bus.restart = 1'b1;
    at(53);
    bus.restart = 1'b0;
    bus.pll_main_lock = 1'b1;
    at(54);
    bus.restart = 1'b1;
    at(55);
    bus.restart = 1'b0;
    at(65);
    rst = 1'b1;
    at(67);

    // Timeout retries every 68 cycles with locks held low; counter saturates at 255.
    do_reset();
    push(0,         30, ev(1, 1, 1, 0, 8'd0,   8'd0));
    push(67,        31, ev(0, 1, 1, 0, 8'd0,   8'd0));
    push(68,        32, ev(1, 1, 1, 0, 8'd1,   8'd0));
    push(71,        33, ev(1, 1, 1, 0, 8'd1,   8'd0));
    push(72,        34, ev(0, 1, 1, 0, 8'd1,   8'd0));
    push(136,       35, ev(1, 1, 1, 0, 8'd2,   8'd0));
    push(68*255-1,  36, ev(0, 1, 1, 0, 8'd254, 8'd0));
    push(68*255,    37, ev(1, 1, 1, 0, 8'd255, 8'd0));
    push(68*256,    38, ev(1, 1, 1, 0, 8'd255, 8'd0));
    push(68*300,    39, ev(1, 1, 1, 0, 8'd255, 8'd0));
    at(68*300 + 1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
